// File: rtl/ps2_key_event.sv
// ps2_key_event: turns the raw PS/2 Set-2 byte stream into clean key events.
// One event per make/break, with typematic repeats suppressed. Events are
// queued in a small FIFO so no key transition is lost while the CPU polls.
//
// Ports
//   iCLK        single clock, rising edge
//   iRST        synchronous active-high reset
//   iSCAN_STB   one-cycle strobe: iSCAN_CODE holds a new byte
//   iSCAN_CODE  received byte
//   oEVT_VALID  FIFO head holds an event
//   iEVT_READY  consumer pops head when oEVT_VALID & iEVT_READY
//   oEVT_CODE   key code of head event
//   oEVT_EXT    head event was E0-prefixed
//   oEVT_BREAK  1 = release, 0 = press
//   oOVERFLOW   sticky: an event was dropped because the FIFO was full
module ps2_key_event #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 50000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iSCAN_STB,
  input  logic [7:0] iSCAN_CODE,
  output logic       oEVT_VALID,
  input  logic       iEVT_READY,
  output logic [7:0] oEVT_CODE,
  output logic       oEVT_EXT,
  output logic       oEVT_BREAK,
  output logic       oOVERFLOW
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_SKIP} state_t;

  // Controller replies and padding bytes that never name a key.
  function automatic logic is_discard(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
  endfunction

  state_t          state;
  logic [2:0]      skip_cnt;
  logic [TW-1:0]   tcnt;
  logic            c_vld, c_ext, c_brk;
  logic [7:0]      c_code;

  // ---------------- parser ----------------
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= S_IDLE;
      skip_cnt <= '0;
      tcnt     <= '0;
      c_vld    <= 1'b0;
      c_ext    <= 1'b0;
      c_brk    <= 1'b0;
      c_code   <= '0;
    end else begin
      c_vld <= 1'b0;
      if (iSCAN_STB) begin
        tcnt <= '0;
        case (state)
          S_IDLE: begin
            if (iSCAN_CODE == 8'hE0)      state <= S_EXT;
            else if (iSCAN_CODE == 8'hF0) state <= S_BRK;
            else if (iSCAN_CODE == 8'hE1) begin
              // Pause sends 7 more bytes after E1; swallow them all.
              state    <= S_SKIP;
              skip_cnt <= 3'd7;
            end else if (!is_discard(iSCAN_CODE)) begin
              c_vld <= 1'b1; c_ext <= 1'b0; c_brk <= 1'b0; c_code <= iSCAN_CODE;
            end
          end
          S_EXT: begin
            if (iSCAN_CODE == 8'hF0)      state <= S_EXT_BRK;
            else if (iSCAN_CODE == 8'hE0) state <= S_EXT;
            else begin
              state <= S_IDLE;
              // E0 12 is the fake shift some keyboards wrap around nav keys.
              if (!is_discard(iSCAN_CODE) && iSCAN_CODE != 8'h12) begin
                c_vld <= 1'b1; c_ext <= 1'b1; c_brk <= 1'b0; c_code <= iSCAN_CODE;
              end
            end
          end
          S_BRK: begin
            state <= S_IDLE;
            if (!is_discard(iSCAN_CODE)) begin
              c_vld <= 1'b1; c_ext <= 1'b0; c_brk <= 1'b1; c_code <= iSCAN_CODE;
            end
          end
          S_EXT_BRK: begin
            state <= S_IDLE;
            if (!is_discard(iSCAN_CODE) && iSCAN_CODE != 8'h12) begin
              c_vld <= 1'b1; c_ext <= 1'b1; c_brk <= 1'b1; c_code <= iSCAN_CODE;
            end
          end
          S_SKIP: begin
            skip_cnt <= skip_cnt - 3'd1;
            if (skip_cnt <= 3'd1) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE) begin
        // Abandon a half-received sequence after TIMEOUT quiet cycles.
        if (tcnt == TW'(TIMEOUT - 1)) begin
          state <= S_IDLE;
          tcnt  <= '0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end
    end
  end

  // ---------------- repeat suppression ----------------
  logic [8:0] last_code;
  logic       held;
  logic [8:0] c_key;
  logic       repeat_hit, push;

  assign c_key      = {c_ext, c_code};
  assign repeat_hit = c_vld && !c_brk && held && (c_key == last_code);
  assign push       = c_vld && !repeat_hit;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      last_code <= '0;
      held      <= 1'b0;
    end else if (c_vld) begin
      if (!c_brk && !repeat_hit) begin
        last_code <= c_key;
        held      <= 1'b1;
      end else if (c_brk && c_key == last_code) begin
        held <= 1'b0;
      end
    end
  end

  // ---------------- event FIFO ----------------
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          full, empty, pop, wr_ok, ovf;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && iEVT_READY;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_ok = push && (!full || pop);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= {c_ext, c_brk, c_code};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !wr_ok) ovf <= 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign oEVT_VALID                       = !empty;
  assign {oEVT_EXT, oEVT_BREAK, oEVT_CODE} = mem[rd_ptr];
  assign oOVERFLOW                        = ovf;
endmodule

// File: tb/tb_ps2_key_event.sv
// Bench for ps2_key_event: directed byte sequences, an event-level reference
// model compared against the DUT head every cycle, plus literal event logs.
module tb_ps2_key_event;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 100;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       iSCAN_STB = 1'b0;
  logic [7:0] iSCAN_CODE = '0;
  logic       iEVT_READY = 1'b0;
  logic       oEVT_VALID, oEVT_EXT, oEVT_BREAK, oOVERFLOW;
  logic [7:0] oEVT_CODE;

  ps2_key_event #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSCAN_STB(iSCAN_STB), .iSCAN_CODE(iSCAN_CODE),
    .oEVT_VALID(oEVT_VALID), .iEVT_READY(iEVT_READY), .oEVT_CODE(oEVT_CODE),
    .oEVT_EXT(oEVT_EXT), .oEVT_BREAK(oEVT_BREAK), .oOVERFLOW(oOVERFLOW)
  );

  always #5 iCLK = ~iCLK;

  int n_vec = 0;
  int n_err = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Events are {ext, break, code}. The byte stream is interpreted with a few
  // prefix flags; an event decided at a strobe enters the queue one edge later.
  logic [9:0] mq[$];
  bit         m_ovf, pend_v, pe, pb, held, m_pop;
  logic [9:0] pend;
  logic [8:0] last;
  int         skip, gap, m_sz;

  task model_byte(input logic [7:0] b);
    if (skip > 0) begin skip--; return; end
    if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF}) begin
      pe = 0; pb = 0; return;
    end
    if (!pb) begin
      if (b == 8'hE0) begin pe = 1; return; end
      if (b == 8'hF0) begin pb = 1; return; end
      if (b == 8'hE1 && !pe) begin skip = 7; return; end
    end
    if (pe && b == 8'h12) begin pe = 0; pb = 0; return; end
    if (pb) begin
      if (last == {pe, b}) held = 0;
      pend = {pe, 1'b1, b}; pend_v = 1;
    end else if (!(held && last == {pe, b})) begin
      last = {pe, b}; held = 1;
      pend = {pe, 1'b0, b}; pend_v = 1;
    end
    pe = 0; pb = 0;
  endtask

  always @(posedge iCLK) begin
    if (iRST) begin
      mq.delete(); m_ovf = 0; pend_v = 0; pe = 0; pb = 0;
      skip = 0; held = 0; last = '0; gap = 0;
    end else begin
      m_sz  = mq.size();
      m_pop = (m_sz > 0) && iEVT_READY;
      if (m_pop) void'(mq.pop_front());
      if (pend_v) begin
        if (m_sz == DEPTH && !m_pop) m_ovf = 1;
        else mq.push_back(pend);
      end
      pend_v = 0;
      if (iSCAN_STB) begin
        if (gap >= TIMEOUT) begin pe = 0; pb = 0; skip = 0; end
        gap = 0;
        model_byte(iSCAN_CODE);
      end else begin
        gap++;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge iCLK) begin
    if (started) begin
      chk("valid_ovf", {30'd0, oEVT_VALID, oOVERFLOW}, {30'd0, mq.size() > 0, m_ovf});
      if (mq.size() > 0)
        chk("head", {22'd0, oEVT_EXT, oEVT_BREAK, oEVT_CODE}, {22'd0, mq[0]});
    end
  end

  // Log of events actually handed to the consumer.
  logic [9:0] got[$];
  always @(posedge iCLK)
    if (!iRST && oEVT_VALID === 1'b1 && iEVT_READY)
      got.push_back({oEVT_EXT, oEVT_BREAK, oEVT_CODE});

  task automatic chk_log(input string name, input int n,
                         input logic [9:0] e0 = 0, input logic [9:0] e1 = 0,
                         input logic [9:0] e2 = 0, input logic [9:0] e3 = 0,
                         input logic [9:0] e4 = 0);
    logic [9:0] e [5];
    e = '{e0, e1, e2, e3, e4};
    chk({name, "_count"}, got.size(), n);
    for (int i = 0; i < n; i++)
      if (i < got.size()) chk($sformatf("%s_%0d", name, i), {22'd0, got[i]}, {22'd0, e[i]});
    got.delete();
  endtask

  // ---------------- stimulus ----------------
  task cyc(input logic stb, input logic [7:0] c);
    iSCAN_STB = stb; iSCAN_CODE = c;
    @(posedge iCLK); #1;
    iSCAN_STB = 1'b0;
  endtask
  task send(input logic [7:0] b); cyc(1'b1, b); endtask
  task idle(input int n); repeat (n) cyc(1'b0, 8'h00); endtask

  task chk_zero(input string name);
    chk(name, {20'd0, oEVT_VALID, oEVT_CODE, oEVT_EXT, oEVT_BREAK, oOVERFLOW}, 32'd0);
  endtask

  initial begin
    @(posedge iCLK); #1;
    started = 1;
    idle(1);
    chk_zero("reset_outputs");
    iRST = 1'b0;

    // Plain press/release with exact latency.
    iEVT_READY = 1'b1;
    send(8'h1C);
    chk("lat_n1_valid", {31'd0, oEVT_VALID}, 32'd0);
    idle(1);
    chk("lat_n2_valid", {31'd0, oEVT_VALID}, 32'd1);
    chk("lat_n2_code", {24'd0, oEVT_CODE}, 32'h1C);
    send(8'hF0); send(8'h1C); idle(4);
    chk_log("press_release", 2, 10'h01C, 10'h11C);

    // Typematic repeats suppressed.
    repeat (5) send(8'h1C);
    send(8'hF0); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C); idle(4);
    chk_log("typematic", 4, 10'h01C, 10'h11C, 10'h01C, 10'h11C);

    // Extended key and fake shift.
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h12); idle(4);
    chk_log("extended", 2, 10'h275, 10'h375);

    // Pause sequence and controller noise.
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'hAA); send(8'hFA); send(8'h29); idle(4);
    chk_log("pause_noise", 1, 10'h029);

    // Overflow, then push+pop while full.
    iEVT_READY = 1'b0;
    send(8'h15); send(8'h16); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    idle(3);
    chk("ovf_valid", {31'd0, oEVT_VALID}, 32'd1);
    chk("ovf_flag", {31'd0, oOVERFLOW}, 32'd1);
    send(8'h35);
    iEVT_READY = 1'b1;
    idle(1);
    iEVT_READY = 1'b0;
    idle(2);
    chk("full_pushpop_valid", {31'd0, oEVT_VALID}, 32'd1);
    chk_log("full_pushpop", 1, 10'h015);
    iEVT_READY = 1'b1;
    idle(6);
    chk_log("drain", 4, 10'h016, 10'h01D, 10'h024, 10'h035);
    chk("ovf_sticky", {31'd0, oOVERFLOW}, 32'd1);

    // Timeout boundary: 99 quiet cycles keeps the prefix, 100 drops it.
    iRST = 1'b1; idle(1); iRST = 1'b0;
    chk("ovf_cleared", {31'd0, oOVERFLOW}, 32'd0);
    send(8'hF0); idle(TIMEOUT - 1); send(8'h1C);
    send(8'hF0); idle(TIMEOUT);     send(8'h1C);
    idle(4);
    chk_log("timeout", 2, 10'h11C, 10'h01C);

    // Reset mid-sequence with a queued event.
    iEVT_READY = 1'b0;
    send(8'h44); idle(2);
    chk("pre_reset_valid", {31'd0, oEVT_VALID}, 32'd1);
    send(8'hE0);
    iRST = 1'b1; idle(1);
    chk_zero("mid_reset_outputs");
    iRST = 1'b0;
    iEVT_READY = 1'b1;
    send(8'h75); idle(4);
    chk_log("after_reset", 1, 10'h075);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_key_event.md
# ps2_key_event

Converts the raw PS/2 Set-2 byte stream from the keyboard receiver into clean key events: one event per make or break, with typematic auto-repeats suppressed. It sits between `ps2_keyboard` and the processor's `pixel_data_in` path. It buffers events in a small FIFO so that no key transition is lost while the processor polls.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `TIMEOUT`, 50000: idle iCLK cycles after which a partial prefix sequence is abandoned.
- `iCLK` input 1: the single clock; all logic is rising-edge.
- `iRST` input 1: reset, synchronous and active-high.
- `iSCAN_STB` input 1: one-cycle strobe meaning `iSCAN_CODE` holds a newly received byte. It is already synchronous to `iCLK`.
- `iSCAN_CODE` input 8: received byte; sampled only when `iSCAN_STB`=1.
- `oEVT_VALID` output 1: FIFO head holds an event.
- `iEVT_READY` input 1: consumer pops the head when `oEVT_VALID`=1 and `iEVT_READY`=1.
- `oEVT_CODE` output 8: key code of the head event.
- `oEVT_EXT` output 1: head event was E0-prefixed.
- `oEVT_BREAK` output 1: 1 = release, 0 = press.
- `oOVERFLOW` output 1: sticky flag; set when an event is dropped because the FIFO is full.

## Operation
- Parser FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP.
- IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - E1 → SKIP, with the skip counter loaded to 7. This discards the rest of the Pause sequence.
  - 00, AA, EE, FA, FC, FD, FE or FF: discarded, stay in IDLE.
  - Any other byte: make candidate with ext=0, then → IDLE.
- EXT:
  - F0 → EXT_BRK.
  - E0 → stay in EXT.
  - 12 (fake shift): discarded, → IDLE.
  - Discard-list byte → IDLE.
  - Any other byte: make candidate with ext=1, then → IDLE.
- BRK: any byte except the discard list produces a break with ext=0, then → IDLE. A discard-list byte → IDLE with no event.
- EXT_BRK: same as BRK with ext=1. A code 12 is discarded.
- SKIP: each strobe decrements the counter; at 0 → IDLE. No events are produced in SKIP.
- Repeat suppression:
  - Registers `last_code[8:0]` ({ext, code}) and `held`.
  - A make candidate equal to `last_code` while `held`=1 is dropped.
  - Otherwise the make is emitted, `last_code` is loaded and `held`=1.
  - A break equal to `last_code` clears `held`.
  - Every break is emitted.
- Timeout: in EXT, BRK, EXT_BRK or SKIP, a counter runs while no strobe arrives. It reloads on every strobe. On reaching `TIMEOUT` the FSM → IDLE with no event.
- FIFO:
  - DEPTH×10 bits wide ({ext, break, code}), with wrapping read and write pointers plus an occupancy count of width log2(DEPTH)+1.
  - Push when full and no pop: the event is dropped and `oOVERFLOW` ←1.
  - Push when full with a simultaneous pop: both are accepted; occupancy is unchanged.
  - Push and pop together at any other occupancy: both are accepted; occupancy is unchanged.
  - Pop when empty: ignored.
- Reset:
  - FSM → IDLE; counters → 0.
  - `held` = 0; `last_code` = 0.
  - FIFO is emptied; `oOVERFLOW` = 0.
  - A sequence in flight is discarded. Bytes arriving afterward are parsed fresh.

## Timing
- Reset values:
  - `oEVT_VALID` = 0.
  - `oEVT_CODE` = 00.
  - `oEVT_EXT` = 0.
  - `oEVT_BREAK` = 0.
  - `oOVERFLOW` = 0.
- Parser: one byte per strobe. Strobes may arrive on consecutive cycles.
- Event latency:
  - Final-byte strobe in cycle N → candidate registered at the edge ending N.
  - FIFO write at the edge ending N+1.
  - If the FIFO was empty, `oEVT_VALID`=1 in cycle N+2.
- Head outputs come from the FIFO storage at the read pointer. They are stable while `oEVT_VALID`=1 and no pop occurs.
- Pop: a handshake in cycle M advances the head at the end of M. The next entry, or `oEVT_VALID`=0, appears in cycle M+1.
- Throughput: one event per cycle in and out.

## Test plan
- Plain press and release: strobes 1C, F0, 1C; `iEVT_READY`=1 → two events: {code 1C, ext 0, break 0} at N+2 after the first strobe, then {1C, 0, 1}.
- Typematic: 1C ×5, then F0 1C, then 1C → events: make 1C, break 1C, make 1C. The four repeated makes produce nothing.
- Extended key: E0 75, E0 F0 75 → make {75, ext 1} then break {75, ext 1}. Sequence E0 12 → no event.
- Pause and noise: E1 14 77 E1 F0 14 F0 77, then AA, FA, then 29 → exactly one event, make 29.
- Overflow and concurrency, `DEPTH`=4, `iEVT_READY`=0: six distinct makes →
  - `oEVT_VALID`=1 with four entries held and `oOVERFLOW`=1.
  - Then ready=1 together with another make: occupancy stays 4.
  - Drained order: first three stored makes, fourth, then the new one.
- Timeout and reset mid-sequence, `TIMEOUT`=100:
  - F0, wait 100 cycles, then 1C → make 1C.
  - E0, then iRST for 1 cycle, then 75 → make {75, ext 0}; all outputs were 0 during reset.
